// File: rtl/grf_write_arbiter_pkg.sv
// Shared widths and constants for the GRF
// write-port arbitration slice.
package grf_write_arbiter_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/grf_write_arbiter_rr_arbiter.sv
// Round-robin arbiter with optional fixed
// priority for requester 0.
module grf_write_arbiter_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2,
  parameter bit PRIO0 = 1'b1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    if (PRIO0 && req[0]) begin
      gnt[0] = 1'b1;
      any    = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        j = IDX_W'((int'(ptr) + k) % N);
        // index 0 only ever wins via priority
        if (!any && req[j] &&
            !(PRIO0 && j == '0)) begin
          gnt[j] = 1'b1;
          idx    = j;
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// Arbitrates NUM_REQ writers onto the single
// GRF write port with a one-cycle output stage.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter bit PRIO0   = 1'b1,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        reqValid,
  output logic [NUM_REQ-1:0]        reqReady,
  input  logic [NUM_REQ*REG_W-1:0]  reqReg,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  input  logic [NUM_REQ*DATA_W-1:0] reqPC,
  output logic                      writeEnable,
  output logic [REG_W-1:0]          writeReg,
  output logic [DATA_W-1:0]         writeData,
  output logic [DATA_W-1:0]         PCReg,
  output logic [IDX_W-1:0]          grantIdx,
  output logic [31:0]               pendingMask
);

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gidx;
  logic               gany;
  logic               xfer;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              we_q, we_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wpc_q, wpc_d;

  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] sel_pc;
  logic [31:0]       pend;

  grf_write_arbiter_rr_arbiter #(
    .N    (NUM_REQ),
    .IDX_W(IDX_W),
    .PRIO0(PRIO0)
  ) u_arb (
    .req(reqValid),
    .ptr(rr_ptr_q),
    .gnt(gnt),
    .idx(gidx),
    .any(gany)
  );

  assign reqReady = gnt & {NUM_REQ{~reset}};
  assign xfer     = gany & ~reset;
  assign grantIdx = gidx;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    sel_pc   = '0;
    pend     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_reg  = reqReg[REG_W*i +: REG_W];
        sel_data = reqData[DATA_W*i +: DATA_W];
        sel_pc   = reqPC[DATA_W*i +: DATA_W];
      end
      if (reqValid[i] && !reqReady[i])
        pend[reqReg[REG_W*i +: REG_W]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign pendingMask = pend;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    wpc_d    = wpc_q;
    if (xfer) begin
      we_d    = (sel_reg != REG_ZERO);
      wreg_d  = sel_reg;
      wdata_d = sel_data;
      wpc_d   = sel_pc;
      // a priority win for 0 leaves the rotation alone
      if (!(PRIO0 && gidx == '0))
        rr_ptr_d = (gidx == IDX_W'(NUM_REQ - 1))
                   ? '0 : gidx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      wpc_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      wpc_q    <= wpc_d;
    end
  end

  assign writeEnable = we_q;
  assign writeReg    = wreg_q;
  assign writeData   = wdata_q;
  assign PCReg       = wpc_q;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Bench: round-robin and priority variants
// driven together, checked against a model.
module tb_grf_write_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  valid;
  logic [14:0] regs;
  logic [95:0] data;
  logic [95:0] pc;

  logic [2:0]  a_rdy, b_rdy;
  logic        a_we, b_we;
  logic [4:0]  a_wreg, b_wreg;
  logic [31:0] a_wdata, b_wdata;
  logic [31:0] a_pc, b_pc;
  logic [1:0]  a_gidx, b_gidx;
  logic [31:0] a_pend, b_pend;

  int errors = 0;
  int checks = 0;

  grf_write_arbiter #(
    .NUM_REQ(3), .PRIO0(1'b0), .IDX_W(2)
  ) dut_rr (
    .clk(clk), .reset(rst),
    .reqValid(valid), .reqReady(a_rdy),
    .reqReg(regs), .reqData(data),
    .reqPC(pc), .writeEnable(a_we),
    .writeReg(a_wreg), .writeData(a_wdata),
    .PCReg(a_pc), .grantIdx(a_gidx),
    .pendingMask(a_pend)
  );

  grf_write_arbiter #(
    .NUM_REQ(3), .PRIO0(1'b1), .IDX_W(2)
  ) dut_pr (
    .clk(clk), .reset(rst),
    .reqValid(valid), .reqReady(b_rdy),
    .reqReg(regs), .reqData(data),
    .reqPC(pc), .writeEnable(b_we),
    .writeReg(b_wreg), .writeData(b_wdata),
    .PCReg(b_pc), .grantIdx(b_gidx),
    .pendingMask(b_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Model: who wins given valid set and pointer
  function automatic int pick(
    input logic [2:0] v, input int ptr,
    input bit prio);
    if (prio && v[0]) return 0;
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (ptr + k) % 3;
      if (!(prio && j == 0) && v[j]) return j;
    end
    return -1;
  endfunction

  int          mptr [2];
  logic        mwe  [2];
  logic [4:0]  mreg [2];
  logic [31:0] mdat [2];
  logic [31:0] mpc  [2];

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mptr[m] = 0; mwe[m] = 0;
        mreg[m] = 0; mdat[m] = 0; mpc[m] = 0;
      end else begin
        int g;
        g = pick(valid, mptr[m], m == 1);
        if (g >= 0) begin
          mreg[m] = regs[5*g +: 5];
          mdat[m] = data[32*g +: 32];
          mpc[m]  = pc[32*g +: 32];
          mwe[m]  = (mreg[m] != 0);
          if (!(m == 1 && g == 0))
            mptr[m] = (g + 1) % 3;
        end else begin
          mwe[m] = 0;
        end
      end
    end
  end

  task automatic cmp_one(
    input int m, input logic [2:0] rdy,
    input logic [1:0] gidx,
    input logic [31:0] pend, input logic we,
    input logic [4:0] wreg,
    input logic [31:0] wdat,
    input logic [31:0] wpc);
    int g;
    logic [2:0] er;
    logic [31:0] ep;
    g  = rst ? -1 : pick(valid, mptr[m], m == 1);
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    ep = 0;
    for (int i = 0; i < 3; i++)
      if (valid[i] && !er[i])
        ep[regs[5*i +: 5]] = 1'b1;
    ep[0] = 1'b0;
    chk($sformatf("m%0d ready", m), 32'(rdy), 32'(er));
    if (g >= 0)
      chk($sformatf("m%0d gidx", m), 32'(gidx), 32'(g));
    chk($sformatf("m%0d pend", m), pend, ep);
    chk($sformatf("m%0d we", m), 32'(we), 32'(mwe[m]));
    chk($sformatf("m%0d wreg", m), 32'(wreg),
        32'(mreg[m]));
    chk($sformatf("m%0d wdata", m), wdat, mdat[m]);
    chk($sformatf("m%0d pc", m), wpc, mpc[m]);
  endtask

  always @(negedge clk) begin
    cmp_one(0, a_rdy, a_gidx, a_pend, a_we,
            a_wreg, a_wdata, a_pc);
    cmp_one(1, b_rdy, b_gidx, b_pend, b_we,
            b_wreg, b_wdata, b_pc);
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  int rr_exp [4] = '{0, 1, 2, 0};

  initial begin
    rst = 1'b1; valid = '0;
    regs = '0; data = '0; pc = '0;
    repeat (2) @(negedge clk);
    chk("rst we", 32'(b_we), 0);
    chk("rst ready", 32'(b_rdy), 0);
    nxt();
    rst = 1'b0;

    // single request
    valid = 3'b010;
    regs  = {5'd0, 5'd10, 5'd0};
    data  = {32'd0, 32'd16, 32'd0};
    pc    = {32'd0, 32'h12345678, 32'd0};
    @(negedge clk);
    chk("single ready", 32'(b_rdy), 32'b010);
    chk("single gidx", 32'(b_gidx), 1);
    nxt();
    valid = 3'b000;
    @(negedge clk);
    chk("single we", 32'(b_we), 1);
    chk("single wreg", 32'(b_wreg), 10);
    chk("single wdata", b_wdata, 16);
    chk("single pc", b_pc, 32'h12345678);

    // round robin, PRIO0=0
    do_reset();
    valid = 3'b111;
    regs  = {5'd3, 5'd2, 5'd1};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rr gidx", 32'(a_gidx), 32'(rr_exp[c]));
      chk("rr pend", a_pend,
          32'h0e & ~(32'd1 << (rr_exp[c] + 1)));
      if (c > 0)
        chk("rr wreg", 32'(a_wreg),
            32'(rr_exp[c-1] + 1));
      nxt();
    end
    valid = 3'b000;

    // priority, PRIO0=1
    do_reset();
    valid = 3'b101;
    regs  = {5'd6, 5'd0, 5'd4};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("prio ready", 32'(b_rdy), 32'b001);
      nxt();
    end
    valid = 3'b100;
    @(negedge clk);
    chk("prio drop", 32'(b_rdy), 32'b100);
    nxt();
    valid = 3'b000;

    // register-zero write
    do_reset();
    valid = 3'b001;
    regs  = '0;
    data  = {32'd0, 32'd0, 32'd3};
    pc    = {32'd0, 32'd0, 32'h00000abc};
    @(negedge clk);
    chk("zero ready", 32'(a_rdy[0]), 1);
    chk("zero pend", a_pend, 0);
    nxt();
    valid = 3'b000;
    @(negedge clk);
    chk("zero we", 32'(a_we), 0);
    chk("zero wdata", a_wdata, 3);
    chk("zero pc", a_pc, 32'habc);

    // same-register contention
    do_reset();
    valid = 3'b011;
    regs  = {5'd0, 5'd5, 5'd5};
    data  = {32'd0, 32'd9, 32'd7};
    @(negedge clk);
    chk("same g0", 32'(a_gidx), 0);
    nxt();
    valid = 3'b010;
    @(negedge clk);
    chk("same ready1", 32'(a_rdy), 32'b010);
    chk("same d7", a_wdata, 7);
    nxt();
    valid = 3'b000;
    @(negedge clk);
    chk("same d9", a_wdata, 9);
    chk("same we", 32'(a_we), 1);

    // reset mid-operation
    do_reset();
    valid = 3'b111;
    regs  = {5'd3, 5'd2, 5'd1};
    data  = {32'd33, 32'd22, 32'd11};
    @(negedge clk);
    chk("mid g0", 32'(a_gidx), 0);
    nxt();
    chk("mid we1", 32'(a_we), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid we0", 32'(a_we), 0);
    chk("mid wreg0", 32'(a_wreg), 0);
    chk("mid rdy0", 32'(a_rdy), 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("mid regrant", 32'(a_gidx), 0);
    nxt();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      valid = 3'($urandom);
      regs  = 15'($urandom);
      for (int i = 0; i < 3; i++) begin
        data[32*i +: 32] = $urandom;
        pc[32*i +: 32]   = $urandom;
      end
      nxt();
    end
    rst = 1'b0;
    valid = '0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/grf_write_arbiter.md
Name: grf_write_arbiter

Overview:
Shares the single GRF write port between NUM_REQ independent writers: pipeline writeback, the multi-cycle mult/div unit, and spare slots. Uses a valid/ready handshake per requester and round-robin grant, with an optional fixed-priority override for requester 0. The winning request is registered and drives the GRF writeEnable/writeReg/writeData/PCReg inputs one cycle later. Sits between the writeback sources and grf.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
PRIO0, 1, 1 = requester 0 always wins when valid; 0 = pure round-robin over all requesters
IDX_W, 2, width of grant index; must equal ceil(log2(NUM_REQ)), minimum 1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
reqValid  input  NUM_REQ  per-requester write request
reqReady  output  NUM_REQ  per-requester accept (combinational grant)
reqReg  input  NUM_REQ*5  packed destination register numbers; slot i = bits [5i+4:5i]
reqData  input  NUM_REQ*32  packed write data; slot i = bits [32i+31:32i]
reqPC  input  NUM_REQ*32  packed PC of the writing instruction, for the write log
writeEnable  output  1  to grf
writeReg  output  5  to grf
writeData  output  32  to grf
PCReg  output  32  to grf
grantIdx  output  IDX_W  index of the requester granted this cycle (valid only when |reqReady)
pendingMask  output  32  bit r set when any reqValid slot targets register r and is not granted this cycle

Behaviour:
- Reset (async, active-high):
  - writeEnable=0, writeReg=0, writeData=0, PCReg=0.
  - Round-robin pointer rrPtr=0.
  - reqReady forced to 0 while reset is high.
- Grant, combinational, at most one per cycle:
  - PRIO0=1 and reqValid[0]: grant 0.
  - Otherwise: first valid index found scanning rrPtr, rrPtr+1, ..., wrapping modulo NUM_REQ.
  - With PRIO0=1, the scan starts at rrPtr but skips index 0.
- Handshake:
  - reqReady[i]=1 only for the granted i; transfer occurs on valid&ready.
  - A requester holds reqReg/reqData/reqPC stable while valid and not ready.
  - Dropping valid before it is granted is legal; the request is withdrawn.
- Pointer update: on a transfer from index g, rrPtr <= (g+1) mod NUM_REQ. No transfer: rrPtr holds. A priority grant of requester 0 does not move rrPtr.
- Output stage, latency 1 cycle from transfer to GRF write:
  - On a transfer: writeReg<=reqReg[g], writeData<=reqData[g], PCReg<=reqPC[g].
  - writeEnable<=1 if reqReg[g]!=0; if reqReg[g]==0, writeEnable<=0. The request is still accepted (reqReady=1), and writeReg/writeData/PCReg still update.
  - No transfer: writeEnable<=0; writeReg/writeData/PCReg hold their previous values.
- The GRF never backpressures; one write retires every cycle a grant exists. No stall input.
- Simultaneous same-register requests: granted in arbitration order. The later grant lands on a later cycle, so the last-granted value wins. Ordering between requesters is the producers' responsibility.
- pendingMask:
  - Combinational OR of decoded reqReg over valid-and-not-granted slots.
  - Bit 0 is always 0.
  - Hazard logic uses it to stall readers of in-flight registers.
- Reset mid-operation:
  - A registered write in flight is cancelled: writeEnable drops asynchronously.
  - A requester whose request was not granted before reset re-presents it after reset deasserts.
- Width rules: all data passed unmodified; no arithmetic except the modulo pointer increment. Unused grantIdx values (NUM_REQ not a power of 2) never occur.

Decomposition:
- Shared package/header (mips_defs): REG_W=5, DATA_W=32, REG_ZERO=5'd0.
- One natural sub-module: rr_arbiter (request vector, pointer, prio0 flag -> one-hot grant + index). It is reusable for the later HI/LO and memory-port arbiters.
- Output register and pendingMask decode stay in the top module.

Test Plan:
- Single request: reqValid=3'b010, reqReg[1]=10, reqData=16, reqPC=32'h12345678 -> reqReady=3'b010, grantIdx=1. Next cycle: writeEnable=1, writeReg=10, writeData=16, PCReg=32'h12345678.
- Round-robin, PRIO0=0: all three valid and held for 4 cycles from rrPtr=0 -> grants 0,1,2,0. writeReg sequence follows one cycle later; pendingMask always shows the two waiting registers.
- Priority, PRIO0=1: req0 and req2 valid for 3 cycles -> req0 granted every cycle, req2 reqReady=0. Drop req0 -> req2 granted in that same cycle.
- Register-zero write: reqReg[0]=0, reqData=3 -> reqReady[0]=1. Next cycle: writeEnable=0, writeData=3, PCReg updated. pendingMask[0]=0 throughout.
- Same-register contention: req0 and req1 both target reg 5, data 7 and 9, PRIO0=0, rrPtr=0 -> writes land on consecutive cycles: 7 then 9.
- Reset mid-operation: assert reset between clock edges, the cycle after a grant -> writeEnable falls immediately, outputs=0, reqReady=0. After release, rrPtr=0 and the held requests are re-granted starting at index 0.
